// File: rtl/vga_scanout.sv
// ----------------------------------------------------------------------------
// vga_scanout
//
// Read-side master for the 320x240 RGB444 framebuffer. Generates 640x480@60
// VGA timing from aclk4 (four clocks per pixel), requests one buffer read per
// displayed pixel with 2x upscaling, and drives registered colour and sync
// pins toward the board DAC. The buffer is never written.
//
// Each pixel slot spans four aclk4 cycles (phase 0..3). Addresses and select
// are presented for the slot being fetched. The read data is taken on the
// last phase. It is shown on the pins for the whole of the following slot,
// so every visible output lags the counters by exactly one slot.
//
// Ports
//   aclk4          in   1   system clock, 4x pixel rate
//   aresetn        in   1   asynchronous active-low reset
//   enable_i       in   1   run scanout; low holds everything at reset values
//   x_o            out  12  buffer column address
//   y_o            out  12  buffer row address
//   select_o       out  1   buffer access request
//   wen_o          out  1   buffer write enable, tied low
//   rdata_i        in   12  buffer read data {R[11:8], G[7:4], B[3:0]}
//   vga_r_o        out  4   red, registered
//   vga_g_o        out  4   green, registered
//   vga_b_o        out  4   blue, registered
//   vga_hs_o       out  1   horizontal sync, registered
//   vga_vs_o       out  1   vertical sync, registered
//   frame_start_o  out  1   one-cycle pulse on the first cycle of slot (0,0)
// ----------------------------------------------------------------------------
module vga_scanout #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter logic        SYNC_POL    = 1'b0
) (
    input  logic        aclk4,
    input  logic        aresetn,
    input  logic        enable_i,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        select_o,
    output logic        wen_o,
    input  logic [11:0] rdata_i,
    output logic [3:0]  vga_r_o,
    output logic [3:0]  vga_g_o,
    output logic [3:0]  vga_b_o,
    output logic        vga_hs_o,
    output logic        vga_vs_o,
    output logic        frame_start_o
);

    localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // IDLE is the one cycle after enable rises (or reset releases) in which
    // the counters still sit at zero, so phase 0 of slot (0,0) starts on the
    // next cycle with its outputs already registered.
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [9:0]  hCount_q, hCount_d;
    logic [9:0]  vCount_q, vCount_d;

    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        select_q, select_d;
    logic [11:0] pixel_q, pixel_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        frameStart_q, frameStart_d;

    logic        slotEnd;
    logic        curActive;
    logic        nextActive;
    logic        curHsync;
    logic        curVsync;

    // Slot/phase sequencing. Dropping enable parks the counters at the origin,
    // so a restart always begins a fresh frame and no partial slot completes.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        hCount_d = hCount_q;
        vCount_d = vCount_q;
        if (!enable_i) begin
            state_d  = ST_IDLE;
            phase_d  = 2'd0;
            hCount_d = 10'd0;
            vCount_d = 10'd0;
        end else if (state_q == ST_IDLE) begin
            state_d  = ST_RUN;
            phase_d  = 2'd0;
            hCount_d = 10'd0;
            vCount_d = 10'd0;
        end else begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
                if (hCount_q == H_LAST) begin
                    hCount_d = 10'd0;
                    vCount_d = (vCount_q == V_LAST) ? 10'd0 : vCount_q + 10'd1;
                end else begin
                    hCount_d = hCount_q + 10'd1;
                end
            end
        end
    end

    // Region decodes. "cur" describes the slot now ending (used for the
    // one-slot-delayed display side); "next" describes the cycle the fetch
    // registers are being loaded for.
    always_comb begin
        slotEnd    = (state_q == ST_RUN) && (phase_q == 2'd3);
        curActive  = (hCount_q < H_ACT) && (vCount_q < V_ACT);
        nextActive = (hCount_d < H_ACT) && (vCount_d < V_ACT);
        curHsync   = (hCount_q >= H_SYNC_START) && (hCount_q < H_SYNC_END);
        curVsync   = (vCount_q >= V_SYNC_START) && (vCount_q < V_SYNC_END);
    end

    // Output next-state. Fetch outputs are computed from the next counter
    // values so they line up with the slot they belong to. Display outputs
    // change only on the edge that closes a slot; since that edge also opens
    // the next slot's phase 0, the pins stay steady for four cycles. The
    // pixel register doubles as the colour output and loads zero for blank
    // slots, which gives blanking without any logic after the flops.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        select_d     = 1'b0;
        frameStart_d = 1'b0;
        pixel_d      = pixel_q;
        hs_d         = hs_q;
        vs_d         = vs_q;
        if (!enable_i) begin
            x_d     = 12'd0;
            y_d     = 12'd0;
            pixel_d = 12'd0;
            hs_d    = ~SYNC_POL;
            vs_d    = ~SYNC_POL;
        end else begin
            if (nextActive) begin
                x_d = 12'(hCount_d >> SCALE_SHIFT);
                y_d = 12'(vCount_d >> SCALE_SHIFT);
            end
            select_d     = nextActive && (phase_d != 2'd3);
            frameStart_d = (phase_d == 2'd0) && (hCount_d == 10'd0) && (vCount_d == 10'd0);
            if (slotEnd) begin
                pixel_d = curActive ? rdata_i : 12'd0;
                hs_d    = curHsync ? SYNC_POL : ~SYNC_POL;
                vs_d    = curVsync ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    // State and output registers; reset forces blank, idle, syncs inactive.
    always_ff @(posedge aclk4 or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            phase_q      <= 2'd0;
            hCount_q     <= 10'd0;
            vCount_q     <= 10'd0;
            x_q          <= 12'd0;
            y_q          <= 12'd0;
            select_q     <= 1'b0;
            pixel_q      <= 12'd0;
            hs_q         <= ~SYNC_POL;
            vs_q         <= ~SYNC_POL;
            frameStart_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            x_q          <= x_d;
            y_q          <= y_d;
            select_q     <= select_d;
            pixel_q      <= pixel_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign select_o      = select_q;
    assign wen_o         = 1'b0;
    assign vga_r_o       = pixel_q[11:8];
    assign vga_g_o       = pixel_q[7:4];
    assign vga_b_o       = pixel_q[3:0];
    assign vga_hs_o      = hs_q;
    assign vga_vs_o      = vs_q;
    assign frame_start_o = frameStart_q;

endmodule

// File: tb/tb_vga_scanout.sv
// ----------------------------------------------------------------------------
// tb_vga_scanout
//
// Two instances share clock and reset. dutA uses the real 640x480 timing and
// covers horizontal behaviour, reset, and enable handling over the first few
// lines. dutB uses a tiny 14x12-slot raster so that vertical blanking, vsync
// and frame wrap can be reached in a few hundred cycles.
//
// Cycle numbering: the negedge at which enable is raised is cycle 0. Each
// tick advances one posedge and samples on the following negedge, so slot S
// phase p is observed at cycle 1 + 4*S + p.
// ----------------------------------------------------------------------------
module tb_vga_scanout;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        sel;
        logic        wen;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } obs_t;

    typedef struct {
        int          cyc;
        logic [11:0] rdata;
        obs_t        exp;
    } vec_t;

    logic        aclk4 = 1'b0;
    logic        aresetn;
    logic        enableA, enableB;
    logic [11:0] rdataA, rdataB;

    logic [11:0] xA, yA, xB, yB;
    logic        selA, wenA, hsA, vsA, fsA;
    logic        selB, wenB, hsB, vsB, fsB;
    logic [3:0]  rA, gA, bA, rB, gB, bB;

    obs_t        obsA, obsB;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        bRun = 1'b0;
    logic        vblankBad = 1'b0;

    vec_t        vecA[$];
    vec_t        vecB[$];

    always #5 aclk4 = ~aclk4;

    vga_scanout dutA (
        .aclk4        (aclk4),
        .aresetn      (aresetn),
        .enable_i     (enableA),
        .x_o          (xA),
        .y_o          (yA),
        .select_o     (selA),
        .wen_o        (wenA),
        .rdata_i      (rdataA),
        .vga_r_o      (rA),
        .vga_g_o      (gA),
        .vga_b_o      (bA),
        .vga_hs_o     (hsA),
        .vga_vs_o     (vsA),
        .frame_start_o(fsA)
    );

    vga_scanout #(
        .H_ACTIVE   (8),
        .H_FP       (2),
        .H_SYNC     (2),
        .H_BP       (2),
        .V_ACTIVE   (6),
        .V_FP       (2),
        .V_SYNC     (2),
        .V_BP       (2),
        .SCALE_SHIFT(1),
        .SYNC_POL   (1'b0)
    ) dutB (
        .aclk4        (aclk4),
        .aresetn      (aresetn),
        .enable_i     (enableB),
        .x_o          (xB),
        .y_o          (yB),
        .select_o     (selB),
        .wen_o        (wenB),
        .rdata_i      (rdataB),
        .vga_r_o      (rB),
        .vga_g_o      (gB),
        .vga_b_o      (bB),
        .vga_hs_o     (hsB),
        .vga_vs_o     (vsB),
        .frame_start_o(fsB)
    );

    assign obsA = {xA, yA, selA, wenA, rA, gA, bA, hsA, vsA, fsA};
    assign obsB = {xB, yB, selB, wenB, rB, gB, bB, hsB, vsB, fsB};

    // Expected-output builder; the write enable is always expected low.
    function automatic obs_t mkObs(input logic [11:0] x, input logic [11:0] y,
                                   input logic sel, input logic [11:0] rgb,
                                   input logic hs, input logic vs, input logic fs);
        obs_t o;
        o.x   = x;
        o.y   = y;
        o.sel = sel;
        o.wen = 1'b0;
        o.rgb = rgb;
        o.hs  = hs;
        o.vs  = vs;
        o.fs  = fs;
        return o;
    endfunction

    function automatic vec_t mkVec(input int c, input logic [11:0] rd,
                                   input logic [11:0] x, input logic [11:0] y,
                                   input logic sel, input logic [11:0] rgb,
                                   input logic hs, input logic vs, input logic fs);
        vec_t v;
        v.cyc   = c;
        v.rdata = rd;
        v.exp   = mkObs(x, y, sel, rgb, hs, vs, fs);
        return v;
    endfunction

    // Drive every DUT input at once from the stimulus process.
    task automatic applyStimulus(input logic enA, input logic [11:0] rdA,
                                 input logic enB, input logic [11:0] rdB);
        enableA = enA;
        rdataA  = rdA;
        enableB = enB;
        rdataB  = rdB;
    endtask

    // One clock: through the posedge, sample at the negedge. While dutB is
    // running, every cycle from the first blank slot after the last visible
    // line to the end of the frame must show no colour and no request.
    task automatic tick();
        @(posedge aclk4);
        @(negedge aclk4);
        cyc++;
        if (bRun && cyc >= 337 && cyc <= 672 && (obsB.rgb != 12'd0 || obsB.sel))
            vblankBad = 1'b1;
    endtask

    task automatic runTo(input int target);
        if (target < cyc) begin
            failures++;
            $display("[TB] FAIL runTo target=%0d already passed, now at cycle %0d", target, cyc);
        end
        while (cyc < target) tick();
    endtask

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got x=%0d y=%0d sel=%b wen=%b rgb=%h hs=%b vs=%b fs=%b required x=%0d y=%0d sel=%b wen=%b rgb=%h hs=%b vs=%b fs=%b",
                     name, cyc, act.x, act.y, act.sel, act.wen, act.rgb, act.hs, act.vs, act.fs,
                     exp.x, exp.y, exp.sel, exp.wen, exp.rgb, exp.hs, exp.vs, exp.fs);
        end
    endtask

    // Main sequence: reset, dutA line timing table, async reset mid-line,
    // enable drop and restart, then dutB frame timing table.
    initial begin
        obs_t resetObs;
        resetObs = mkObs(12'd0, 12'd0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0);

        // dutA: real 640x480 timing, rdata held at ABC
        vecA.push_back(mkVec(   1, 12'hABC,  12'd0, 12'd0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b1));
        vecA.push_back(mkVec(   3, 12'hABC,  12'd0, 12'd0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(   4, 12'hABC,  12'd0, 12'd0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(   5, 12'hABC,  12'd0, 12'd0, 1'b1, 12'hABC, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(   9, 12'hABC,  12'd1, 12'd0, 1'b1, 12'hABC, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(2553, 12'hABC, 12'd319, 12'd0, 1'b1, 12'hABC, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(2558, 12'hABC, 12'd319, 12'd0, 1'b1, 12'hABC, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(2561, 12'hABC, 12'd319, 12'd0, 1'b0, 12'hABC, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(2565, 12'hABC, 12'd319, 12'd0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(2628, 12'hABC, 12'd319, 12'd0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(2629, 12'hABC, 12'd319, 12'd0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0));
        vecA.push_back(mkVec(3012, 12'hABC, 12'd319, 12'd0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0));
        vecA.push_back(mkVec(3013, 12'hABC, 12'd319, 12'd0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(3200, 12'hABC, 12'd319, 12'd0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(3201, 12'hABC,  12'd0, 12'd0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(3205, 12'hABC,  12'd0, 12'd0, 1'b1, 12'hABC, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(5828, 12'hABC, 12'd319, 12'd0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(5829, 12'hABC, 12'd319, 12'd0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0));
        vecA.push_back(mkVec(6401, 12'hABC,  12'd0, 12'd1, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0));
        vecA.push_back(mkVec(6406, 12'hABC,  12'd0, 12'd1, 1'b1, 12'hABC, 1'b1, 1'b1, 1'b0));

        // dutB: 8+2+2+2 slots per line, 6+2+2+2 lines, rdata held at FFF
        vecB.push_back(mkVec(  1, 12'hFFF, 12'd0, 12'd0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b1));
        vecB.push_back(mkVec(  5, 12'hFFF, 12'd0, 12'd0, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b0));
        vecB.push_back(mkVec(309, 12'hFFF, 12'd3, 12'd2, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b0));
        vecB.push_back(mkVec(313, 12'hFFF, 12'd3, 12'd2, 1'b0, 12'hFFF, 1'b1, 1'b1, 1'b0));
        vecB.push_back(mkVec(337, 12'hFFF, 12'd3, 12'd2, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0));
        vecB.push_back(mkVec(342, 12'hFFF, 12'd3, 12'd2, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0));
        vecB.push_back(mkVec(381, 12'hFFF, 12'd3, 12'd2, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0));
        vecB.push_back(mkVec(452, 12'hFFF, 12'd3, 12'd2, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0));
        vecB.push_back(mkVec(453, 12'hFFF, 12'd3, 12'd2, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0));
        vecB.push_back(mkVec(564, 12'hFFF, 12'd3, 12'd2, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0));
        vecB.push_back(mkVec(565, 12'hFFF, 12'd3, 12'd2, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0));
        vecB.push_back(mkVec(672, 12'hFFF, 12'd3, 12'd2, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0));
        vecB.push_back(mkVec(673, 12'hFFF, 12'd0, 12'd0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b1));
        vecB.push_back(mkVec(677, 12'hFFF, 12'd0, 12'd0, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b0));

        aresetn = 1'b0;
        applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);
        repeat (3) @(negedge aclk4);
        checkOutput("resetA", obsA, resetObs);
        checkOutput("resetB", obsB, resetObs);
        aresetn = 1'b1;
        tick();
        tick();
        checkOutput("disabledA", obsA, resetObs);

        $display("[TB] dutA line timing table");
        applyStimulus(1'b1, 12'hABC, 1'b0, 12'h000);
        cyc = 0;
        foreach (vecA[i]) begin
            applyStimulus(1'b1, vecA[i].rdata, 1'b0, 12'h000);
            runTo(vecA[i].cyc);
            checkOutput($sformatf("vecA[%0d]", i), obsA, vecA[i].exp);
        end

        // Reset asserted mid-line must blank everything without waiting for a clock
        aresetn = 1'b0;
        #1;
        checkOutput("asyncResetA", obsA, resetObs);
        @(posedge aclk4);
        @(negedge aclk4);
        aresetn = 1'b1;
        cyc = 0;

        // After reset release with enable still high, scanout restarts at (0,0);
        // slot (300,1) phase 1 is cycle 1 + 4*1100 + 1
        runTo(4402);
        checkOutput("midLineA", obsA, mkObs(12'd150, 12'd0, 1'b1, 12'hABC, 1'b1, 1'b1, 1'b0));
        applyStimulus(1'b0, 12'hABC, 1'b0, 12'h000);
        tick();
        checkOutput("enableDropA", obsA, resetObs);
        tick();
        checkOutput("disabledHoldA", obsA, resetObs);
        applyStimulus(1'b1, 12'hABC, 1'b0, 12'h000);
        cyc = 0;
        tick();
        checkOutput("restartA", obsA, mkObs(12'd0, 12'd0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b1));
        runTo(5);
        checkOutput("restartPixelA", obsA, mkObs(12'd0, 12'd0, 1'b1, 12'hABC, 1'b1, 1'b1, 1'b0));

        $display("[TB] dutB frame timing table");
        checkOutput("disabledB", obsB, resetObs);
        applyStimulus(1'b1, 12'hABC, 1'b1, 12'hFFF);
        cyc = 0;
        bRun = 1'b1;
        foreach (vecB[i]) begin
            applyStimulus(1'b1, 12'hABC, 1'b1, vecB[i].rdata);
            runTo(vecB[i].cyc);
            checkOutput($sformatf("vecB[%0d]", i), obsB, vecB[i].exp);
        end
        bRun = 1'b0;

        checks++;
        if (vblankBad) begin
            failures++;
            $display("[TB] FAIL vblankB got colour or select during vertical blank, required rgb=000 sel=0");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
